// File: rtl/x4_out_buffer_if.sv
// ---------------------------------------------------------------------------
// Module   : x4_out_buffer_if
// Purpose  : Handshake bundle between the upstream stage, the buffer and downstream.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface x4_out_buffer_if #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_parity;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flush;
  logic [$clog2(DEPTH):0]  level;
  logic [15:0]             xfer_count;
  logic                    overrun;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_parity, out_valid, level, xfer_count, overrun
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_parity, out_valid, level, xfer_count, overrun
  );
endinterface

`default_nettype wire

// File: rtl/x4_out_buffer.sv
// ---------------------------------------------------------------------------
// Module   : x4_out_buffer
// Purpose  : Registered FIFO for packed primary outputs with stored parity and flush.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module x4_out_buffer #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  x4_out_buffer_if.slave bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam logic [c_lvl_w-1:0] c_depth   = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0]     r_par;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic [15:0]          r_xfer_count;
  logic                 r_overrun;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic                 w_wr;
  logic                 w_rd;
  logic [c_lvl_w-1:0]   w_level_next;

  // flush wins over any transfer presented in the same cycle
  always_comb begin
    w_wr         = bus.in_valid && r_in_ready && !bus.flush;
    w_rd         = r_out_valid && bus.out_ready && !bus.flush;
    w_level_next = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_next = r_level + c_lvl_one;
      2'b01:   w_level_next = r_level - c_lvl_one;
      default: w_level_next = r_level;
    endcase
    if (bus.flush) begin
      w_level_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_xfer_count <= '0;
      r_overrun    <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_par        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_level     <= w_level_next;
      // next state is FLUSH exactly when flush is high, so the handshakes follow it
      r_in_ready  <= !bus.flush && (w_level_next < c_depth);
      r_out_valid <= !bus.flush && (w_level_next != '0);
      if (bus.flush) begin
        r_state  <= FLUSH;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (bus.in_valid && !r_in_ready) begin
          r_overrun <= 1'b1;
        end
        if (w_wr) begin
          r_mem[r_wr_ptr] <= bus.in_data;
          r_par[r_wr_ptr] <= ^bus.in_data;
          r_wr_ptr        <= r_wr_ptr + c_ptr_one;
          if (r_xfer_count != 16'hFFFF) begin
            r_xfer_count <= r_xfer_count + 16'd1;
          end
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        case (r_state)
          IDLE:    if (w_wr) r_state <= RUN;
          RUN:     if (w_level_next == '0) r_state <= IDLE;
          FLUSH:   r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_mem[r_rd_ptr];
  assign bus.out_parity = r_par[r_rd_ptr];
  assign bus.level      = r_level;
  assign bus.xfer_count = r_xfer_count;
  assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_x4_out_buffer.sv
// ---------------------------------------------------------------------------
// Module   : tb_x4_out_buffer
// Purpose  : Randomised scoreboard bench for x4_out_buffer against a queue model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_x4_out_buffer;

  localparam int W = 71;
  localparam int D = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  x4_out_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  x4_out_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: entries held in a queue, status kept as plain counters
  logic [W:0]  sb [$];
  int          m_level = 0;
  logic        m_fl    = 1'b0;
  logic        m_ovr   = 1'b0;
  logic [15:0] m_xfer  = 16'd0;
  logic        m_rdy   = 1'b1;
  logic        m_ov    = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(posedge clock);
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(1'b0, '0, 1'b1, 1'b0);
    while (bus.level != '0 && n < 20) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_level", 96'(bus.level), 96'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // status checker and model update
  initial begin
    logic        iv, fl, ordy;
    logic [W-1:0] d;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("level",      96'(bus.level),      96'(m_level));
        check("in_ready",   96'(bus.in_ready),   96'(m_rdy));
        check("out_valid",  96'(bus.out_valid),  96'(m_ov));
        check("overrun",    96'(bus.overrun),    96'(m_ovr));
        check("xfer_count", 96'(bus.xfer_count), 96'(m_xfer));
      end
      @(posedge clock);
      iv = bus.in_valid; fl = bus.flush; ordy = bus.out_ready; d = bus.in_data;
      if (reset) begin
        m_level = 0; m_fl = 1'b0; m_ovr = 1'b0; m_xfer = 16'd0;
        sb.delete();
      end else if (fl) begin
        m_level = 0; m_fl = 1'b1;
        sb.delete();
      end else begin
        if (iv && !m_rdy) m_ovr = 1'b1;
        if (iv && m_rdy) begin
          sb.push_back({^d, d});
          if (m_xfer != 16'hFFFF) m_xfer = m_xfer + 16'd1;
          m_level++;
        end
        if (m_ov && ordy) m_level--;
        m_fl = 1'b0;
      end
      m_rdy = (m_level < D) && !m_fl;
      m_ov  = (m_level != 0) && !m_fl;
    end
  end

  // output monitor: every accepted read is compared with the queue head
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clock);
      if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_empty: out_valid=1 with no entry expected at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("out_data",   96'(bus.out_data),   96'(e[W-1:0]));
          check("out_parity", 96'(bus.out_parity), 96'(e[W]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_level",    96'(bus.level),      96'(0));
    check("rst_valid",    96'(bus.out_valid),  96'(0));
    check("rst_ready",    96'(bus.in_ready),   96'(1));
    check("rst_xfer",     96'(bus.xfer_count), 96'(0));
    check("rst_out_data", 96'(bus.out_data),   96'(0));

    // single write, one-cycle latency
    v = '0; v[0] = 1'b1;
    drive(1'b1, v, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("single_valid",  96'(bus.out_valid),  96'(1));
    check("single_data",   96'(bus.out_data),   96'(1));
    check("single_parity", 96'(bus.out_parity), 96'(1));
    check("single_xfer",   96'(bus.xfer_count), 96'(1));
    drain();

    // overfill: fifth write refused
    check("pre_overrun", 96'(bus.overrun), 96'(0));
    repeat (5) drive(1'b1, rnd(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("full_level",   96'(bus.level),    96'(D));
    check("full_ready",   96'(bus.in_ready), 96'(0));
    check("full_overrun", 96'(bus.overrun),  96'(1));

    // streaming from full, pointers wrap
    repeat (8) drive(1'b1, rnd(), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drain();

    // flush at level 3 with a concurrent write
    repeat (3) drive(1'b1, rnd(), 1'b0, 1'b0);
    drive(1'b1, rnd(), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    @(negedge clock);
    check("flush_level", 96'(bus.level),     96'(0));
    check("flush_valid", 96'(bus.out_valid), 96'(0));
    check("flush_ready", 96'(bus.in_ready),  96'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("flush_hold_ready", 96'(bus.in_ready), 96'(0));
    @(posedge clock);
    #1 check("flush_exit_ready", 96'(bus.in_ready), 96'(1));

    // randomised traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 29) == 0));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drain();

    // asynchronous reset with two entries held
    drive(1'b1, rnd(), 1'b0, 1'b0);
    drive(1'b1, rnd(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 96'(bus.out_valid), 96'(0));
    check("async_level", 96'(bus.level),     96'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b1, rnd(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    // saturation of the transfer counter
    @(posedge clock);
    #2;
    force dut.r_xfer_count = 16'hFFFE;
    m_xfer = 16'hFFFE;
    #1 release dut.r_xfer_count;
    repeat (3) drive(1'b1, rnd(), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clock);
    check("xfer_sat", 96'(bus.xfer_count), 96'(16'hFFFF));
    drain();

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/x4_out_buffer.md
X4_OUT_BUFFER -- requirements
Module: x4_out_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 71, giving the primary-output vector width (po00..po70 packed, po00 = bit 0).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the FIFO entries; legal values are powers of two, 2 to 16.
REQ-003 Port: clock  input  1  single rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_data  input  WIDTH  packed primary outputs from the upstream combinational stage.
REQ-006 Port: in_valid  input  1  in_data qualifies this cycle.
REQ-007 Port: in_ready  output  1  the block accepts in_data this cycle.
REQ-008 Port: out_data  output  WIDTH  head-of-FIFO vector.
REQ-009 Port: out_parity  output  1  even parity (XOR) of out_data, stored at write time.
REQ-010 Port: out_valid  output  1  out_data/out_parity are valid.
REQ-011 Port: out_ready  input  1  downstream accepts this cycle.
REQ-012 Port: flush  input  1  synchronous request to discard all entries.
REQ-013 Port: level  output  clog2(DEPTH)+1  current entry count.
REQ-014 Port: xfer_count  output  16  accepted-write count, saturating at 16'hFFFF.
REQ-015 Port: overrun  output  1  sticky flag: in_valid seen while not in_ready.

Function
REQ-016 A write SHALL occur on a rising edge when in_valid && in_ready; a read SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be (level < DEPTH) && state != FLUSH; it SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL be (level != 0) && state != FLUSH; out_data SHALL be driven from registers, not from in_data.
REQ-019 Latency SHALL be one cycle: data written at edge N SHALL appear on out_data with out_valid high after edge N when the FIFO was empty.
REQ-020 A simultaneous read and write SHALL leave level unchanged, including at level == DEPTH (write permitted only when in_ready was high) and at level == 0 (no read possible).
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-022 out_parity SHALL equal the XOR of all WIDTH bits of the entry, computed on in_data at write.
REQ-023 xfer_count SHALL increment by 1 per write and hold at 16'hFFFF.
REQ-024 overrun SHALL set on any cycle with in_valid && !in_ready and clear only on reset.
REQ-025 The state machine SHALL have states IDLE (level 0), RUN (level > 0), and FLUSH.
REQ-026 IDLE->RUN on write; RUN->IDLE when level reaches 0; any state->FLUSH when flush is sampled high.
REQ-027 In FLUSH, pointers and level SHALL clear on entry edge; the block SHALL stay in FLUSH while flush is high and go to IDLE the edge after flush falls.
REQ-028 flush SHALL take priority over a simultaneous write or read; that write SHALL be dropped, that read SHALL NOT count, and overrun SHALL NOT set from it.
REQ-029 xfer_count SHALL NOT be cleared by flush.

Reset
REQ-030 On reset asserted, state SHALL be IDLE immediately; level, pointers, xfer_count, and overrun SHALL be 0; out_valid SHALL be 0; in_ready SHALL be 1 on the first edge after release.
REQ-031 out_data and stored entries SHALL be 0 after reset.
REQ-032 Reset asserted mid-transfer SHALL discard all entries without requiring a clock edge.

Verification
REQ-033 Single write of 71'h1 with out_ready=0 -> next cycle out_valid=1, out_data=71'h1, out_parity=1, level=1, xfer_count=1.
REQ-034 Five back-to-back writes with DEPTH=4 and out_ready=0 -> in_ready=0 after the 4th, the 5th is not accepted, overrun=1, level=4, xfer_count=4.
REQ-035 Full FIFO with in_valid=1 and out_ready=1 continuously for 8 cycles -> level stays 4, data is read out in order, and pointers wrap twice.
REQ-036 flush pulsed for 2 cycles at level=3 with a concurrent write -> level=0, out_valid=0, in_ready=0 during FLUSH, IDLE one edge after flush falls, xfer_count unchanged.
REQ-037 reset asserted asynchronously between edges at level=2 -> out_valid and level go to 0 before the next edge; the first post-reset write reads back correctly.
REQ-038 Force xfer_count to 16'hFFFE then perform 3 writes -> xfer_count=16'hFFFF and holds.
